// File: rtl/gx4000_asic_page_if.sv
`default_nettype none
// ============================================================================
// Module   : gx4000_asic_page_if
// Brief    : CPU bus bundle between the Z80 side and the ASIC page mapper.
// Revision : 1.0
// ============================================================================
interface gx4000_asic_page_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_mreq;
    logic        cpu_iorq;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_data_out;
    logic        rd_hit;

    modport master (
        output cpu_addr, cpu_data_in, cpu_mreq, cpu_iorq, cpu_wr, cpu_rd,
        input  cpu_data_out, rd_hit
    );

    modport slave (
        input  cpu_addr, cpu_data_in, cpu_mreq, cpu_iorq, cpu_wr, cpu_rd,
        output cpu_data_out, rd_hit
    );
endinterface
`default_nettype wire

// File: rtl/gx4000_asic_page.sv
`default_nettype none
// ============================================================================
// Module   : gx4000_asic_page
// Brief    : Plus ASIC register page mapper: RMR2 decode, page registers and
//            palette RAM mapped at &4000-&7FFF once unlocked.
// Revision : 1.0
// ============================================================================
module gx4000_asic_page #(
    parameter int PAL_ENTRIES = 32
) (
    input  wire logic             clk_sys,
    input  wire logic             reset,
    gx4000_asic_page_if.slave     cpu,
    input  wire logic             plus_mode,
    input  wire logic             asic_valid,
    input  wire logic [4:0]       pal_idx,
    output logic                  page_active,
    output logic [1:0]            lrom_sel,
    output logic [2:0]            rom_bank,
    output logic [7:0]            pri_line,
    output logic [7:0]            split_line,
    output logic [15:0]           split_addr,
    output logic [7:0]            soft_scroll,
    output logic [7:0]            ivr,
    output logic [11:0]           pal_rgb
);

    logic        r_wr_q;
    logic [11:0] r_pal [PAL_ENTRIES];

    logic        w_wr_edge;
    logic        w_page_addr;
    logic        w_rmr2_wr;
    logic        w_mem_wr;
    logic        w_pal_hit;
    logic        w_reg_hit;
    logic [4:0]  w_pal_sel;
    logic        w_pal_ok;
    logic [11:0] w_pal_entry;
    logic [7:0]  w_rd_data;

    assign w_wr_edge   = cpu.cpu_wr & ~r_wr_q;
    assign w_page_addr = (cpu.cpu_addr[15:14] == 2'b01);
    assign w_pal_hit   = (cpu.cpu_addr[15:6] == 10'b0110_0100_00);
    assign w_reg_hit   = (cpu.cpu_addr[15:3] == 13'h0D00) && (cpu.cpu_addr[2:0] <= 3'd5);
    assign w_pal_sel   = cpu.cpu_addr[5:1];
    assign w_pal_ok    = (int'(w_pal_sel) < PAL_ENTRIES);
    assign w_pal_entry = w_pal_ok ? r_pal[w_pal_sel] : 12'h000;

    // I/O takes precedence: an edge with both qualifiers is only an RMR2 candidate
    assign w_rmr2_wr = plus_mode & w_wr_edge & cpu.cpu_iorq & w_page_addr
                     & (cpu.cpu_data_in[7:5] == 3'b101) & asic_valid;
    assign w_mem_wr  = plus_mode & w_wr_edge & cpu.cpu_mreq & ~cpu.cpu_iorq
                     & page_active & w_page_addr;

    assign cpu.rd_hit = cpu.cpu_rd & cpu.cpu_mreq & ~cpu.cpu_iorq & page_active
                      & plus_mode & w_page_addr;

    always_comb begin
        w_rd_data = 8'hFF;
        if (w_pal_hit && w_pal_ok) begin
            w_rd_data = cpu.cpu_addr[0] ? {4'h0, w_pal_entry[11:8]} : w_pal_entry[7:0];
        end else if (w_reg_hit) begin
            case (cpu.cpu_addr[2:0])
                3'd0:    w_rd_data = pri_line;
                3'd1:    w_rd_data = split_line;
                3'd2:    w_rd_data = split_addr[15:8];
                3'd3:    w_rd_data = split_addr[7:0];
                3'd4:    w_rd_data = soft_scroll;
                3'd5:    w_rd_data = ivr;
                default: w_rd_data = 8'hFF;
            endcase
        end
    end

    assign cpu.cpu_data_out = cpu.rd_hit ? w_rd_data : 8'h00;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wr_q      <= 1'b0;
            page_active <= 1'b0;
            lrom_sel    <= 2'd0;
            rom_bank    <= 3'd0;
            pri_line    <= 8'h00;
            split_line  <= 8'h00;
            split_addr  <= 16'h0000;
            soft_scroll <= 8'h00;
            ivr         <= 8'h00;
        end else begin
            r_wr_q <= cpu.cpu_wr;

            if (w_rmr2_wr) begin
                rom_bank <= cpu.cpu_data_in[2:0];
                if (cpu.cpu_data_in[4:3] == 2'b11) begin
                    page_active <= 1'b1;
                end else begin
                    page_active <= 1'b0;
                    lrom_sel    <= cpu.cpu_data_in[4:3];
                end
            end

            // Losing the unlock unmaps the page but leaves the ROM routing alone
            if (!asic_valid) begin
                page_active <= 1'b0;
            end

            if (w_mem_wr && w_reg_hit) begin
                case (cpu.cpu_addr[2:0])
                    3'd0:    pri_line         <= cpu.cpu_data_in;
                    3'd1:    split_line       <= cpu.cpu_data_in;
                    3'd2:    split_addr[15:8] <= cpu.cpu_data_in;
                    3'd3:    split_addr[7:0]  <= cpu.cpu_data_in;
                    3'd4:    soft_scroll      <= cpu.cpu_data_in;
                    3'd5:    ivr              <= cpu.cpu_data_in;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                r_pal[i] <= 12'h000;
            end
            pal_rgb <= 12'h000;
        end else begin
            pal_rgb <= (int'(pal_idx) < PAL_ENTRIES) ? r_pal[pal_idx] : 12'h000;
            if (w_mem_wr && w_pal_hit && w_pal_ok) begin
                if (cpu.cpu_addr[0]) begin
                    r_pal[w_pal_sel][11:8] <= cpu.cpu_data_in[3:0];
                end else begin
                    r_pal[w_pal_sel][7:0]  <= cpu.cpu_data_in;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gx4000_asic_page.sv
`default_nettype none
// ============================================================================
// Module   : tb_gx4000_asic_page
// Brief    : Directed self-checking bench for the Plus ASIC page mapper.
// Revision : 1.0
// ============================================================================
module tb_gx4000_asic_page;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        plus_mode  = 1'b1;
    logic        asic_valid = 1'b0;
    logic [4:0]  pal_idx    = 5'd0;
    logic        page_active;
    logic [1:0]  lrom_sel;
    logic [2:0]  rom_bank;
    logic [7:0]  pri_line;
    logic [7:0]  split_line;
    logic [15:0] split_addr;
    logic [7:0]  soft_scroll;
    logic [7:0]  ivr;
    logic [11:0] pal_rgb;

    int n_cmp = 0;
    int n_err = 0;

    gx4000_asic_page_if bus ();

    gx4000_asic_page #(.PAL_ENTRIES(32)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .cpu         (bus.slave),
        .plus_mode   (plus_mode),
        .asic_valid  (asic_valid),
        .pal_idx     (pal_idx),
        .page_active (page_active),
        .lrom_sel    (lrom_sel),
        .rom_bank    (rom_bank),
        .pri_line    (pri_line),
        .split_line  (split_line),
        .split_addr  (split_addr),
        .soft_scroll (soft_scroll),
        .ivr         (ivr),
        .pal_rgb     (pal_rgb)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
        bus.cpu_mreq = 1'b0; bus.cpu_iorq = 1'b0;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        bus.cpu_addr = a; bus.cpu_data_in = d;
        bus.cpu_iorq = 1'b1; bus.cpu_mreq = 1'b0; bus.cpu_wr = 1'b1;
        @(negedge clk_sys);
        bus_idle();
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        bus.cpu_addr = a; bus.cpu_data_in = d;
        bus.cpu_iorq = 1'b0; bus.cpu_mreq = 1'b1; bus.cpu_wr = 1'b1;
        @(negedge clk_sys);
        bus_idle();
    endtask

    task automatic read_chk(input string tag, input logic [15:0] a,
                            input logic exp_hit, input logic [7:0] exp_data);
        @(negedge clk_sys);
        bus.cpu_addr = a; bus.cpu_iorq = 1'b0; bus.cpu_mreq = 1'b1; bus.cpu_rd = 1'b1;
        #1;
        check({tag, ".hit"},  {15'd0, bus.rd_hit}, {15'd0, exp_hit});
        check({tag, ".data"}, {8'd0, bus.cpu_data_out}, {8'd0, exp_data});
        bus_idle();
    endtask

    initial begin
        bus.cpu_addr = 16'h0000; bus.cpu_data_in = 8'h00;
        bus_idle();

        // Reset state
        #2;
        check("rst.page_active", {15'd0, page_active}, 16'd0);
        check("rst.pri_line",    {8'd0, pri_line}, 16'd0);
        check("rst.pal_rgb",     {4'd0, pal_rgb}, 16'd0);
        check("rst.data_out",    {8'd0, bus.cpu_data_out}, 16'd0);
        @(negedge clk_sys); @(negedge clk_sys);
        reset = 1'b0;

        // Locked: RMR2 and page traffic ignored
        io_write(16'h7F00, 8'hB8);
        check("locked.page_active", {15'd0, page_active}, 16'd0);
        mem_write(16'h6800, 8'h2A);
        check("locked.pri_line", {8'd0, pri_line}, 16'd0);
        read_chk("locked.rd", 16'h6800, 1'b0, 8'h00);

        // Mapping
        asic_valid = 1'b1;
        io_write(16'h7F00, 8'hB8);
        check("map.page_active", {15'd0, page_active}, 16'd1);
        check("map.rom_bank",    {13'd0, rom_bank}, 16'd0);
        check("map.lrom_sel",    {14'd0, lrom_sel}, 16'd0);
        mem_write(16'h6800, 8'h2A);
        check("map.pri_line", {8'd0, pri_line}, 16'h2A);
        read_chk("map.rd6800", 16'h6800, 1'b1, 8'h2A);
        read_chk("map.rd6900", 16'h6900, 1'b1, 8'hFF);
        read_chk("map.rd8000", 16'h8000, 1'b0, 8'h00);

        // Remaining page registers
        mem_write(16'h6802, 8'h12);
        mem_write(16'h6803, 8'h34);
        mem_write(16'h6804, 8'h56);
        mem_write(16'h6805, 8'h78);
        mem_write(16'h6806, 8'h9C);
        check("reg.split_addr",  split_addr, 16'h1234);
        check("reg.soft_scroll", {8'd0, soft_scroll}, 16'h56);
        check("reg.ivr",         {8'd0, ivr}, 16'h78);
        check("reg.pri_keep",    {8'd0, pri_line}, 16'h2A);
        read_chk("reg.rd6803", 16'h6803, 1'b1, 8'h34);

        // Palette
        mem_write(16'h6402, 8'h5A);
        mem_write(16'h6403, 8'hF7);
        @(negedge clk_sys); pal_idx = 5'd1;
        @(negedge clk_sys);
        check("pal.rgb1", {4'd0, pal_rgb}, 16'h075A);
        read_chk("pal.rd6403", 16'h6403, 1'b1, 8'h07);
        read_chk("pal.rd6402", 16'h6402, 1'b1, 8'h5A);

        // Plus mode off: inert, palette port keeps running
        plus_mode = 1'b0;
        mem_write(16'h6800, 8'h99);
        check("plusoff.pri_line", {8'd0, pri_line}, 16'h2A);
        read_chk("plusoff.rd", 16'h6800, 1'b0, 8'h00);
        check("plusoff.pal_rgb", {4'd0, pal_rgb}, 16'h075A);
        plus_mode = 1'b1;

        // Held strobe: one write, first data only
        @(negedge clk_sys);
        bus.cpu_addr = 16'h6801; bus.cpu_data_in = 8'h10;
        bus.cpu_mreq = 1'b1; bus.cpu_wr = 1'b1;
        @(negedge clk_sys); @(negedge clk_sys);
        bus.cpu_data_in = 8'h20;
        @(negedge clk_sys); @(negedge clk_sys); @(negedge clk_sys);
        bus_idle();
        check("held.split_line", {8'd0, split_line}, 16'h10);

        // Unlock loss for a single cycle
        @(negedge clk_sys); asic_valid = 1'b0;
        @(negedge clk_sys); asic_valid = 1'b1;
        check("unlock.page_active", {15'd0, page_active}, 16'd0);
        check("unlock.rom_bank",    {13'd0, rom_bank}, 16'd0);
        io_write(16'h7F00, 8'hB8);
        check("remap.page_active", {15'd0, page_active}, 16'd1);

        // Unmapping via RMR2 &A9
        io_write(16'h7F00, 8'hA9);
        check("unmap.page_active", {15'd0, page_active}, 16'd0);
        check("unmap.lrom_sel",    {14'd0, lrom_sel}, 16'd1);
        check("unmap.rom_bank",    {13'd0, rom_bank}, 16'd1);
        asic_valid = 1'b0;
        io_write(16'h7F00, 8'hB8);
        check("unmap_locked.page_active", {15'd0, page_active}, 16'd0);
        check("unmap_locked.rom_bank",    {13'd0, rom_bank}, 16'd1);

        // I/O and memory together: only RMR2 acts
        asic_valid = 1'b1;
        @(negedge clk_sys);
        bus.cpu_addr = 16'h6800; bus.cpu_data_in = 8'hBB;
        bus.cpu_iorq = 1'b1; bus.cpu_mreq = 1'b1; bus.cpu_wr = 1'b1;
        @(negedge clk_sys);
        bus_idle();
        check("both.page_active", {15'd0, page_active}, 16'd1);
        check("both.rom_bank",    {13'd0, rom_bank}, 16'd3);
        check("both.lrom_sel",    {14'd0, lrom_sel}, 16'd1);
        check("both.pri_line",    {8'd0, pri_line}, 16'h2A);

        // Read while writing the same register: old value until the edge
        @(negedge clk_sys);
        bus.cpu_addr = 16'h6805; bus.cpu_data_in = 8'h9A;
        bus.cpu_mreq = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_rd = 1'b1;
        #1;
        check("rdwr.old", {8'd0, bus.cpu_data_out}, 16'h78);
        @(negedge clk_sys);
        check("rdwr.new", {8'd0, bus.cpu_data_out}, 16'h9A);
        bus_idle();

        // Palette write and lookup of the same entry in one cycle
        @(negedge clk_sys);
        pal_idx = 5'd0;
        bus.cpu_addr = 16'h6400; bus.cpu_data_in = 8'h31;
        bus.cpu_mreq = 1'b1; bus.cpu_wr = 1'b1;
        @(negedge clk_sys);
        bus_idle();
        check("palsame.old", {4'd0, pal_rgb}, 16'h0000);
        @(negedge clk_sys);
        check("palsame.new", {4'd0, pal_rgb}, 16'h0031);

        // Asynchronous reset mid-write, between clock edges
        @(posedge clk_sys); #2;
        bus.cpu_addr = 16'h7F00; bus.cpu_data_in = 8'hB8;
        bus.cpu_iorq = 1'b1; bus.cpu_wr = 1'b1;
        reset = 1'b1;
        #1;
        check("arst.page_active", {15'd0, page_active}, 16'd0);
        check("arst.split_addr",  split_addr, 16'h0000);
        check("arst.split_line",  {8'd0, split_line}, 16'd0);
        check("arst.rom_bank",    {13'd0, rom_bank}, 16'd0);
        check("arst.pal_rgb",     {4'd0, pal_rgb}, 16'd0);
        pal_idx = 5'd1;
        @(negedge clk_sys); @(negedge clk_sys);
        check("arst.pal_lookup", {4'd0, pal_rgb}, 16'd0);
        reset = 1'b0;
        @(negedge clk_sys);
        check("arst.held_edge", {15'd0, page_active}, 16'd1);
        bus_idle();
        @(negedge clk_sys);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
